// File: rtl/add_multiword_pkg.sv
// rtl/add_multiword_pkg.sv - shared state type and chunk-index sizing for add_multiword_seq
package add_multiword_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int WORDS_DEFAULT = 4;

  // Chunk counter width: $clog2(words), never narrower than one bit
  function automatic int kidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KIDX_W = kidx_width(WORDS_DEFAULT);

endpackage

// File: rtl/PrefixAndOrCfast.sv
// rtl/PrefixAndOrCfast.sv - AND-OR carry prefix network with fast carry-in CI
module PrefixAndOrCfast #(
  parameter int width = 16,
  parameter int speed = 1
) (
  input  logic [width-1:0] GI,
  input  logic [width-1:0] PI,
  input  logic             CI,
  output logic [width-1:0] GO
);

  localparam int L = (width > 1) ? $clog2(width) : 1;

  logic [width-1:0] gl, pl, gn, pn;

  // Group (g,p) over bits [0..i] is built without CI; CI enters in one final AND-OR level
  always_comb begin
    gl = GI;
    pl = PI;
    gn = GI;
    pn = PI;
    if (speed == 0) begin
      for (int i = 1; i < width; i++) begin
        gl[i] = gl[i] | (pl[i] & gl[i-1]);
        pl[i] = pl[i] & pl[i-1];
      end
    end else if (speed == 2) begin
      for (int l = 0; l < L; l++) begin
        gn = gl;
        pn = pl;
        for (int i = 0; i < width; i++) begin
          if (((i >> l) & 1) == 1) begin
            gn[i] = gl[i] | (pl[i] & gl[((i >> l) << l) - 1]);
            pn[i] = pl[i] & pl[((i >> l) << l) - 1];
          end
        end
        gl = gn;
        pl = pn;
      end
    end else begin
      // Brent-Kung: the source node of each level is never updated within that level
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < width; i++) begin
          if (((i + 1) % (2 << l)) == 0) begin
            gl[i] = gl[i] | (pl[i] & gl[i - (1 << l)]);
            pl[i] = pl[i] & pl[i - (1 << l)];
          end
        end
      end
      for (int d = L - 2; d >= 0; d--) begin
        for (int i = 0; i < width; i++) begin
          if ((((i + 1) % (2 << d)) == (1 << d)) && (i >= (2 << d))) begin
            gl[i] = gl[i] | (pl[i] & gl[i - (1 << d)]);
            pl[i] = pl[i] & pl[i - (1 << d)];
          end
        end
      end
    end
    GO = gl | (pl & {width{CI}});
  end

endmodule

// File: rtl/add_chunk_cfast.sv
// rtl/add_chunk_cfast.sv - combinational width-bit chunk adder on PrefixAndOrCfast
module add_chunk_cfast #(
  parameter int width = 16,
  parameter int speed = 1
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             ci,
  output logic [width-1:0] sum,
  output logic             co,
  output logic             cmsb
);

  logic [width-1:0] w_g;
  logic [width-1:0] w_p;
  logic [width-1:0] w_go;

  assign w_g = a & b;
  assign w_p = a ^ b;

  PrefixAndOrCfast #(
    .width(width),
    .speed(speed)
  ) u_prefix (
    .GI(w_g),
    .PI(w_p),
    .CI(ci),
    .GO(w_go)
  );

  assign sum  = w_p ^ {w_go[width-2:0], ci};
  assign co   = w_go[width-1];
  assign cmsb = w_go[width-2];

endmodule

// File: rtl/add_multiword_seq.sv
// rtl/add_multiword_seq.sv - sequential chunk-serial multi-word adder; ADD_MULTIWORD_SUB_EN adds sub_i
module add_multiword_seq
  import add_multiword_pkg::*;
#(
  parameter int width = 16,
  parameter int words = 4,
  parameter int speed = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [words*width-1:0] a_i,
  input  logic [words*width-1:0] b_i,
  input  logic                   cin_i,
`ifdef ADD_MULTIWORD_SUB_EN
  input  logic                   sub_i,
`endif
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [words*width-1:0] sum_o,
  output logic                   cout_o,
  output logic                   ovf_o,
  output logic                   zero_o
);

  localparam int W  = words * width;
  localparam int KW = kidx_width(words);
  localparam logic [KW-1:0] K_LAST = KW'(words - 1);

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic            r_zacc;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [width-1:0] w_sum;
  logic             w_co;
  logic             w_cmsb;
  logic             w_sum_zero;
  logic [W-1:0]     w_sum_ext;
  logic [W-1:0]     w_b_init;
  logic             w_cin_init;

`ifdef ADD_MULTIWORD_SUB_EN
  assign w_b_init   = sub_i ? ~b_i : b_i;
  assign w_cin_init = sub_i | cin_i;
`else
  assign w_b_init   = b_i;
  assign w_cin_init = cin_i;
`endif

  // Operands shift down one chunk per RUN cycle, so chunk k always sits in the low bits
  add_chunk_cfast #(
    .width(width),
    .speed(speed)
  ) u_chunk (
    .a   (r_a[width-1:0]),
    .b   (r_b[width-1:0]),
    .ci  (r_carry),
    .sum (w_sum),
    .co  (w_co),
    .cmsb(w_cmsb)
  );

  assign w_sum_zero = (w_sum == '0);
  assign w_sum_ext  = W'(w_sum);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_a        <= a_i;
            r_b        <= w_b_init;
            r_carry    <= w_cin_init;
            r_k        <= '0;
            r_zacc     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> width;
          r_b     <= r_b >> width;
          // Each new chunk enters at the top; after `words` cycles chunk 0 lands at the bottom
          r_sum   <= (r_sum >> width) | (w_sum_ext << (W - width));
          r_carry <= w_co;
          r_zacc  <= r_zacc & w_sum_zero;
          if (r_k == K_LAST) begin
            r_cout      <= w_co;
            r_ovf       <= w_co ^ w_cmsb;
            r_zero      <= r_zacc & w_sum_zero;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign sum_o       = r_sum;
  assign cout_o      = r_cout;
  assign ovf_o       = r_ovf;
  assign zero_o      = r_zero;

endmodule

// File: tb/tb_add_multiword_seq.sv
// tb/tb_add_multiword_seq.sv - directed self-checking bench for add_multiword_seq (width=8, words=4)
module tb_add_multiword_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
`ifdef ADD_MULTIWORD_SUB_EN
  logic        sub = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int lat;

  always #5 clk = ~clk;

  add_multiword_seq #(
    .width(8),
    .words(4),
    .speed(1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
`ifdef ADD_MULTIWORD_SUB_EN
    .sub_i      (sub),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .cout_o     (cout),
    .ovf_o      (ovf),
    .zero_o     (zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv, output int n);
    @(negedge clk);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    chk("busy_after_accept", {63'd0, in_ready}, 64'd0);
    wait_done(n);
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);
    rst_n = 1'b1;

    // 0xFF + 1: carry crosses from chunk 0 into chunk 1
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    chk("op1_latency", 64'(lat), 64'd4);
    chk("op1_sum", {32'd0, sum}, 64'h0000_0100);
    chk("op1_cout", {63'd0, cout}, 64'd0);
    chk("op1_ovf", {63'd0, ovf}, 64'd0);
    chk("op1_zero", {63'd0, zero}, 64'd0);
    release_done();
    chk("op1_idle_ready", {63'd0, in_ready}, 64'd1);
    chk("op1_idle_valid", {63'd0, out_valid}, 64'd0);

    // Full ripple across all four chunks
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    chk("op2_latency", 64'(lat), 64'd4);
    chk("op2_sum", {32'd0, sum}, 64'h0);
    chk("op2_cout", {63'd0, cout}, 64'd1);
    chk("op2_ovf", {63'd0, ovf}, 64'd0);
    chk("op2_zero", {63'd0, zero}, 64'd1);
    release_done();

    // Positive overflow via carry-in
    run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, lat);
    chk("op3_sum", {32'd0, sum}, 64'h8000_0000);
    chk("op3_cout", {63'd0, cout}, 64'd0);
    chk("op3_ovf", {63'd0, ovf}, 64'd1);
    chk("op3_zero", {63'd0, zero}, 64'd0);
    release_done();

    // Back-pressure in DONE while a new operand is offered
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
    chk("op4_sum", {32'd0, sum}, 64'h2345_6789);
    a = 32'h0000_0001;
    b = 32'h0000_0001;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_sum_hold", {32'd0, sum}, 64'h2345_6789);
      chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("bp_not_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_accepted", {63'd0, in_ready}, 64'd0);
    wait_done(lat);
    chk("bp_new_latency", 64'(lat), 64'd4);
    chk("bp_new_sum", {32'd0, sum}, 64'h0000_0002);
    chk("bp_new_cout", {63'd0, cout}, 64'd0);
    release_done();

    // Reset after two chunks have been registered
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mid_sum", {32'd0, sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_sum", {32'd0, sum}, 64'h0000_0007);
    chk("post_rst_cout", {63'd0, cout}, 64'd0);
    chk("post_rst_zero", {63'd0, zero}, 64'd0);
    release_done();

`ifdef ADD_MULTIWORD_SUB_EN
    sub = 1'b1;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, lat);
    sub = 1'b0;
    chk("sub_sum", {32'd0, sum}, 64'hFFFF_FFFE);
    chk("sub_cout", {63'd0, cout}, 64'd0);
    chk("sub_ovf", {63'd0, ovf}, 64'd0);
    chk("sub_zero", {63'd0, zero}, 64'd0);
    release_done();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
